axi_lite_master_p: RTL

AXI_LITE_MASTER_P -- requirements
Module: axi_lite_master_p

---
 rtl/axi_lite_master_p.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_p.sv
// AXI4-Lite master: turns single-cycle app write/read requests into AXI-Lite transactions.
// Optional per-path abort timer is enabled with the AXIL_MASTER_TIMEOUT_EN macro.
module axi_lite_master_p #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [ADDR_W-1:0]     app_waddr,
    input  logic [DATA_W-1:0]     app_wdata,
    input  logic [DATA_W/8-1:0]   app_wstrb,
    input  logic                  app_wen,
    input  logic [ADDR_W-1:0]     app_raddr,
    input  logic                  app_ren,
    output logic                  app_wbusy,
    output logic                  app_wdone,
    output logic                  app_werror,
    output logic                  app_rbusy,
    output logic                  app_rdone,
    output logic                  app_rerror,
    output logic [DATA_W-1:0]     app_rdata,
    output logic                  app_timeout
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e            w_state_q, w_state_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                wbusy_q, wbusy_d, wdone_q, wdone_d, werror_q, werror_d;

    r_state_e            r_state_q, r_state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic                rbusy_q, rbusy_d, rdone_q, rdone_d, rerror_q, rerror_d;

    logic                w_abort, r_abort;

    function automatic logic resp_ok(input logic [1:0] resp);
        return (resp == 2'b00) || (resp == 2'b01);
    endfunction

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic             timeout_q, timeout_d;

    // Counters run while out of IDLE and restart from zero on every new request.
    assign w_abort   = (w_state_q != W_IDLE) && (wcnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign r_abort   = (r_state_q != R_IDLE) && (rcnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign wcnt_d    = (w_state_q == W_IDLE) ? '0 : wcnt_q + CNT_W'(1);
    assign rcnt_d    = (r_state_q == R_IDLE) ? '0 : rcnt_q + CNT_W'(1);
    assign timeout_d = w_abort | r_abort;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign app_timeout = timeout_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^CNT_W'(TIMEOUT_CYC);
    assign w_abort            = 1'b0;
    assign r_abort            = 1'b0;
    assign app_timeout        = 1'b0;
`endif

    // Write path: AW and W complete independently, then wait for B.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        wdone_d   = 1'b0;
        werror_d  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (app_wen) begin
                    awaddr_d  = app_waddr;
                    wdata_d   = app_wdata;
                    wstrb_d   = app_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d  = 1'b0;
                    wdone_d   = resp_ok(m_axi_bresp);
                    werror_d  = !resp_ok(m_axi_bresp);
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_abort) begin
            w_state_d = W_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            wdone_d   = 1'b0;
            werror_d  = 1'b1;
        end
        wbusy_d = (w_state_d != W_IDLE);
    end

    // Read path: AR then R; app_rdata only updates on a successful response.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdone_d   = 1'b0;
        rerror_d  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (app_ren) begin
                    araddr_d  = app_raddr;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d  = 1'b0;
                    rdone_d   = resp_ok(m_axi_rresp);
                    rerror_d  = !resp_ok(m_axi_rresp);
                    if (resp_ok(m_axi_rresp)) rdata_d = m_axi_rdata;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_abort) begin
            r_state_d = R_IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rdone_d   = 1'b0;
            rerror_d  = 1'b1;
        end
        rbusy_d = (r_state_d != R_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wbusy_q   <= 1'b0;
            wdone_q   <= 1'b0;
            werror_q  <= 1'b0;
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rbusy_q   <= 1'b0;
            rdone_q   <= 1'b0;
            rerror_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wbusy_q   <= wbusy_d;
            wdone_q   <= wdone_d;
            werror_q  <= werror_d;
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rbusy_q   <= rbusy_d;
            rdone_q   <= rdone_d;
            rerror_q  <= rerror_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign app_wbusy     = wbusy_q;
    assign app_wdone     = wdone_q;
    assign app_werror    = werror_q;
    assign app_rbusy     = rbusy_q;
    assign app_rdone     = rdone_q;
    assign app_rerror    = rerror_q;
    assign app_rdata     = rdata_q;

endmodule
